// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one instruction-memory read at a time,
// holds the returned word for decode and pulses pc_advance on acceptance.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky misaligned-PC FAULT state;
// without it fetch_fault is tied low and fetch_pc is used unmodified.
module instr_fetch (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] fetch_pc,
    output logic        pc_advance,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StDrain,
        StHold,
        StFault
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StDrain,
        StHold
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        mem_req_q, mem_req_d;
    logic        inst_valid_q, inst_valid_d;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        pc_misaligned;
    logic        fetch_fault_q, fetch_fault_d;

    assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
`endif

    // Next-state and datapath capture; mem_ack only matters while a request is out.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        case (state_q)
            StIdle: begin
                // One idle cycle lets the PC block settle before fetch_pc is sampled.
                if (!flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_misaligned) begin
                        state_d = StFault;
                    end else begin
                        addr_d  = fetch_pc;
                        state_d = StReq;
                    end
`else
                    addr_d  = fetch_pc;
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                if (mem_ack) begin
                    if (!flush) begin
                        inst_data_d = mem_rdata;
                        inst_pc_d   = addr_q;
                        state_d     = StHold;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (flush) begin
                    // Request cannot be withdrawn; wait out the ack and discard it.
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (flush || inst_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            StFault: begin
                state_d = StFault;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered by decoding the upcoming state.
    always_comb begin
        mem_req_d    = (state_d == StReq) || (state_d == StDrain);
        inst_valid_d = (state_d == StHold);
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_fault_d = (state_d == StFault);
`endif
    end

    // State and registered outputs; synchronous reset drops any outstanding request.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            inst_data_q  <= 32'h0;
            inst_pc_q    <= 32'h0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault_q <= fetch_fault_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

    // Handshake pulse; a flush in HOLD cancels the advance even with ready high.
    assign pc_advance = (state_q == StHold) && inst_ready && !flush && !sys_rst;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; honours FETCH_ALIGN_CHECK_EN for the alignment case.
module tb_instr_fetch;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] fetch_pc;
    logic        pc_advance;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_cmp;
    int n_err;

    instr_fetch dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .fetch_pc    (fetch_pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for that cycle.
    task automatic tick;
        @(posedge sys_clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, ".mem_addr"}, mem_addr, 32'h0);
        chk({tag, ".inst_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, ".inst_data"}, inst_data, 32'h0);
        chk({tag, ".inst_pc"}, inst_pc, 32'h0);
        chk({tag, ".pc_advance"}, {31'h0, pc_advance}, 32'h0);
        chk({tag, ".fetch_fault"}, {31'h0, fetch_fault}, 32'h0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        sys_rst    = 1'b1;
        fetch_pc   = 32'h0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        inst_ready = 1'b0;

        // Reset state
        tick;
        tick;
        #1;
        chk_all_zero("rst");

        // Basic fetch: C1 idle, C2 request with ack, C3 hold with accept
        tick;
        sys_rst = 1'b0;
        #1;
        chk("c1_idle_req", {31'h0, mem_req}, 32'h0);
        tick;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h00500093;
        inst_ready = 1'b1;
        #1;
        chk("c2_req", {31'h0, mem_req}, 32'h1);
        chk("c2_addr", mem_addr, 32'h0);
        chk("c2_valid", {31'h0, inst_valid}, 32'h0);
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("c3_valid", {31'h0, inst_valid}, 32'h1);
        chk("c3_data", inst_data, 32'h00500093);
        chk("c3_pc", inst_pc, 32'h0);
        chk("c3_adv", {31'h0, pc_advance}, 32'h1);
        chk("c3_req", {31'h0, mem_req}, 32'h0);
        tick;
        inst_ready = 1'b0;
        fetch_pc   = 32'h4;
        #1;
        chk("c4_valid", {31'h0, inst_valid}, 32'h0);
        chk("c4_adv", {31'h0, pc_advance}, 32'h0);
        chk("c4_req", {31'h0, mem_req}, 32'h0);

        // Delayed ack (3 wait cycles) and slow decode (4 cycles not ready)
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            chk("wait_req", {31'h0, mem_req}, 32'h1);
            chk("wait_addr", mem_addr, 32'h4);
        end
        tick;
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A00113;
        #1;
        chk("ack_req", {31'h0, mem_req}, 32'h1);
        chk("ack_addr", mem_addr, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            #1;
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_data", inst_data, 32'h00A00113);
            chk("stall_pc", inst_pc, 32'h4);
            chk("stall_adv", {31'h0, pc_advance}, 32'h0);
        end
        tick;
        inst_ready = 1'b1;
        #1;
        chk("accept_adv", {31'h0, pc_advance}, 32'h1);
        chk("accept_valid", {31'h0, inst_valid}, 32'h1);
        tick;
        inst_ready = 1'b0;
        fetch_pc   = 32'h8;
        #1;
        chk("post_accept_valid", {31'h0, inst_valid}, 32'h0);

        // Flush in second REQ cycle, ack arrives two cycles later and is discarded
        tick;
        #1;
        chk("fl_req1", {31'h0, mem_req}, 32'h1);
        chk("fl_addr1", mem_addr, 32'h8);
        tick;
        flush = 1'b1;
        #1;
        chk("fl_req2", {31'h0, mem_req}, 32'h1);
        tick;
        flush    = 1'b0;
        fetch_pc = 32'h100;
        #1;
        chk("drain_req", {31'h0, mem_req}, 32'h1);
        chk("drain_addr", mem_addr, 32'h8);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        tick;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("drain_ack_req", {31'h0, mem_req}, 32'h1);
        chk("drain_ack_valid", {31'h0, inst_valid}, 32'h0);
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("post_drain_req", {31'h0, mem_req}, 32'h0);
        chk("post_drain_valid", {31'h0, inst_valid}, 32'h0);
        tick;
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        #1;
        chk("refetch_addr", mem_addr, 32'h100);
        chk("refetch_req", {31'h0, mem_req}, 32'h1);
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("refetch_valid", {31'h0, inst_valid}, 32'h1);
        chk("refetch_data", inst_data, 32'h12345678);
        chk("refetch_pc", inst_pc, 32'h100);

        // Flush together with ready in HOLD: no advance, refetch current fetch_pc
        flush      = 1'b1;
        inst_ready = 1'b1;
        fetch_pc   = 32'h200;
        #1;
        chk("hold_flush_adv", {31'h0, pc_advance}, 32'h0);
        tick;
        flush      = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk("hold_flush_valid", {31'h0, inst_valid}, 32'h0);
        chk("hold_flush_req", {31'h0, mem_req}, 32'h0);
        tick;
        #1;
        chk("hold_flush_addr", mem_addr, 32'h200);
        chk("hold_flush_req2", {31'h0, mem_req}, 32'h1);

        // Reset mid-REQ, then a stray ack while idle
        tick;
        sys_rst = 1'b1;
        #1;
        chk("midreq_req", {31'h0, mem_req}, 32'h1);
        tick;
        sys_rst   = 1'b0;
        fetch_pc  = 32'h300;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        chk_all_zero("midreq_rst");
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("stray_req", {31'h0, mem_req}, 32'h1);
        chk("stray_addr", mem_addr, 32'h300);
        chk("stray_valid", {31'h0, inst_valid}, 32'h0);
        chk("stray_data", inst_data, 32'h0);
        tick;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h00000013;
        inst_ready = 1'b1;
        #1;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("resume_data", inst_data, 32'h00000013);
        chk("resume_pc", inst_pc, 32'h300);
        chk("resume_adv", {31'h0, pc_advance}, 32'h1);
        tick;
        inst_ready = 1'b0;
        fetch_pc   = 32'h102;
        #1;
        chk("resume_idle", {31'h0, inst_valid}, 32'h0);

        // Misaligned PC
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            chk("fault_flag", {31'h0, fetch_fault}, 32'h1);
            chk("fault_req", {31'h0, mem_req}, 32'h0);
            chk("fault_valid", {31'h0, inst_valid}, 32'h0);
            chk("fault_adv", {31'h0, pc_advance}, 32'h0);
        end
        sys_rst  = 1'b1;
        fetch_pc = 32'h0;
        tick;
        sys_rst = 1'b0;
        #1;
        chk("fault_cleared", {31'h0, fetch_fault}, 32'h0);
        tick;
        #1;
        chk("fault_restart_req", {31'h0, mem_req}, 32'h1);
`else
        tick;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0;
        #1;
        chk("misalign_addr", mem_addr, 32'h102);
        chk("misalign_req", {31'h0, mem_req}, 32'h1);
        chk("misalign_fault", {31'h0, fetch_fault}, 32'h0);
        tick;
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("misalign_valid", {31'h0, inst_valid}, 32'h1);
        chk("misalign_pc", inst_pc, 32'h102);
        chk("misalign_fault2", {31'h0, fetch_fault}, 32'h0);
        tick;
        inst_ready = 1'b0;
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
